// File: rtl/spi_pkg.sv
// Shared definitions for the SPI stream controller: byte width and FSM state encoding.
package spi_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// Push while full and pop while empty are ignored; full is judged before any same-cycle pop.
module spi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_nxt = level;
      if (do_push && !do_pop)
         count_nxt = level + (AW+1)'(1);
      else if (!do_push && do_pop)
         count_nxt = level - (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         level <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spi_stream_ctrl.sv
// Streams bytes from a TX FIFO into the SPI byte master and collects received bytes into an RX FIFO.
// Build option: define SPI_STREAM_RX_FIFO_EN to include the RX FIFO; without it the block is transmit-only.
module spi_stream_ctrl
   import spi_pkg::*;
#(
   parameter int TX_DEPTH   = 16,
   parameter int RX_DEPTH   = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic                        P_clk,
   input  logic                        reset,
   input  logic [BYTE_W-1:0]           s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic [BYTE_W-1:0]           m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [BYTE_W-1:0]           spi_tx_data,
   output logic                        spi_tx_dv,
   input  logic                        spi_tx_ready,
   input  logic [BYTE_W-1:0]           spi_rx_data,
   input  logic                        spi_rx_dv,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic                        rx_overflow,
   output logic                        busy
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t            state;
   state_t            state_nxt;
   logic [GW-1:0]     gap_cnt;
   logic [GW-1:0]     gap_nxt;
   logic              tx_full;
   logic              tx_empty;
   logic              tx_pop;
   logic [BYTE_W-1:0] tx_head;

   assign s_ready = !tx_full;
   assign busy    = (state != ST_IDLE) || !tx_empty;

   spi_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (P_clk),
      .reset     (reset),
      .push      (s_valid),
      .push_data (s_data),
      .pop       (tx_pop),
      .pop_data  (tx_head),
      .full      (tx_full),
      .empty     (tx_empty),
      .level     (tx_level)
   );

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      tx_pop    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!tx_empty && spi_tx_ready) begin
               tx_pop    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (!spi_tx_ready) state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (spi_tx_ready) begin
               if (GAP_CYCLES > 0) begin
                  state_nxt = ST_GAP;
                  gap_nxt   = GW'(GAP_CYCLES - 1);
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == '0)
               state_nxt = ST_IDLE;
            else
               gap_nxt = gap_cnt - GW'(1);
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The DV pulse is the registered image of ISSUE, so it lands two edges after the write.
   always_ff @(posedge P_clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         gap_cnt     <= '0;
         spi_tx_dv   <= 1'b0;
         spi_tx_data <= '0;
      end else begin
         state     <= state_nxt;
         gap_cnt   <= gap_nxt;
         spi_tx_dv <= (state == ST_ISSUE);
         if (tx_pop)
            spi_tx_data <= tx_head;
      end
   end

`ifdef SPI_STREAM_RX_FIFO_EN
   logic              rx_full;
   logic              rx_empty;
   logic [BYTE_W-1:0] rx_head;

   spi_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (P_clk),
      .reset     (reset),
      .push      (spi_rx_dv),
      .push_data (spi_rx_data),
      .pop       (m_ready),
      .pop_data  (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .level     (rx_level)
   );

   assign m_valid = !rx_empty;
   assign m_data  = rx_empty ? '0 : rx_head;

   always_ff @(posedge P_clk or posedge reset) begin
      if (reset)
         rx_overflow <= 1'b0;
      else if (spi_rx_dv && rx_full)
         rx_overflow <= 1'b1;
   end
`else
   logic unused_rx;

   assign unused_rx   = ^{spi_rx_data, spi_rx_dv, m_ready};
   assign m_valid     = 1'b0;
   assign m_data      = '0;
   assign rx_level    = '0;
   assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_stream_ctrl.sv
// Self-checking bench for spi_stream_ctrl with a behavioural SPI byte master (MISO looped back to MOSI).
// Expectations for the RX side follow the SPI_STREAM_RX_FIFO_EN build option.
`timescale 1ns/1ps
module tb_spi_stream_ctrl;

   localparam int TXD = 16;
   localparam int RXD = 16;
   localparam int GAP = 3;

   logic       P_clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] spi_tx_data;
   logic       spi_tx_dv;
   logic       spi_tx_ready;
   logic [7:0] spi_rx_data;
   logic       spi_rx_dv;
   logic [4:0] tx_level;
   logic [4:0] rx_level;
   logic       rx_overflow;
   logic       busy;

   always #5 P_clk = ~P_clk;

   spi_stream_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .GAP_CYCLES(GAP)) dut (
      .P_clk(P_clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .spi_tx_data(spi_tx_data), .spi_tx_dv(spi_tx_dv), .spi_tx_ready(spi_tx_ready),
      .spi_rx_data(spi_rx_data), .spi_rx_dv(spi_rx_dv),
      .tx_level(tx_level), .rx_level(rx_level), .rx_overflow(rx_overflow), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Byte master: accepts DV when idle, drops ready next cycle, returns the byte after a random length.
   logic       stall = 1'b0;
   int         byte_min = 1;
   int         byte_max = 3;
   logic       mst_busy;
   int         mst_cnt;
   logic [7:0] mst_byte;

   always @(posedge P_clk or posedge reset) begin
      if (reset) begin
         spi_tx_ready <= 1'b1;
         spi_rx_dv    <= 1'b0;
         spi_rx_data  <= '0;
         mst_busy     <= 1'b0;
         mst_cnt      <= 0;
         mst_byte     <= '0;
      end else begin
         spi_rx_dv <= 1'b0;
         if (!mst_busy) begin
            if (spi_tx_dv) begin
               mst_busy     <= 1'b1;
               spi_tx_ready <= 1'b0;
               mst_byte     <= spi_tx_data;
               mst_cnt      <= int'($urandom_range(byte_max, byte_min));
            end else begin
               spi_tx_ready <= !stall;
            end
         end else if (mst_cnt > 1) begin
            mst_cnt <= mst_cnt - 1;
         end else begin
            mst_busy     <= 1'b0;
            spi_tx_ready <= !stall;
            spi_rx_dv    <= 1'b1;
            spi_rx_data  <= mst_byte;
         end
      end
   end

   // Reference model: byte queues plus cycle bookkeeping, sampled 1 ns after each rising edge.
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   int         cyc = 0;
   int         rise_cyc = 0;
   int         dv_count = 0;
   int         gap_seen = 0;
   bit         armed = 0;
   bit         mdl_ovf = 0;
   logic       pr_sready = 1'b1;
   logic       pr_mvalid = 1'b0;
   logic [7:0] pr_mdata = '0;
   logic       pr_ready = 1'b1;
   logic       pr_rxdv = 1'b0;
   logic [7:0] pr_rxdata = '0;

   always @(posedge P_clk) begin
      #1;
      cyc++;
      if (reset) begin
         txq.delete();
         rxq.delete();
         armed     = 0;
         mdl_ovf   = 0;
         pr_sready = 1'b1;
         pr_mvalid = 1'b0;
         pr_ready  = 1'b1;
         pr_rxdv   = 1'b0;
      end else begin
         if (s_valid && pr_sready)
            txq.push_back(s_data);
         if (spi_tx_dv) begin
            dv_count++;
            if (txq.size() == 0) check("tx_unexpected_dv", 32'(spi_tx_data), 32'hFFFF_FFFF);
            else check("tx_byte_order", 32'(spi_tx_data), 32'(txq.pop_front()));
            if (armed) begin
               check("gap_to_dv", cyc - rise_cyc, GAP + 3);
               gap_seen++;
               armed = 0;
            end
         end
         // Completion rise with work queued: WAIT_DONE sees it, GAP cycles, then pop and issue.
         if (spi_tx_ready && !pr_ready && spi_rx_dv && txq.size() > 0) begin
            armed    = 1;
            rise_cyc = cyc;
         end
`ifdef SPI_STREAM_RX_FIFO_EN
         begin
            bit rx_was_full;
            rx_was_full = (rxq.size() >= RXD);
            if (pr_mvalid && m_ready) begin
               if (rxq.size() == 0) check("rx_pop_empty", 32'(pr_mdata), 32'hFFFF_FFFF);
               else check("rx_pop_data", 32'(pr_mdata), 32'(rxq.pop_front()));
            end
            if (pr_rxdv) begin
               if (rx_was_full) mdl_ovf = 1;
               else rxq.push_back(pr_rxdata);
            end
         end
         check("rx_level", 32'(rx_level), rxq.size());
         check("m_valid", 32'(m_valid), 32'(rxq.size() > 0));
         check("rx_overflow", 32'(rx_overflow), 32'(mdl_ovf));
         if (rxq.size() > 0) check("m_data_head", 32'(m_data), 32'(rxq[0]));
`else
         check("m_valid_off", 32'(m_valid), 0);
         check("rx_level_off", 32'(rx_level), 0);
         check("rx_overflow_off", 32'(rx_overflow), 0);
`endif
         pr_sready = s_ready;
         pr_mvalid = m_valid;
         pr_mdata  = m_data;
         pr_ready  = spi_tx_ready;
         pr_rxdv   = spi_rx_dv;
         pr_rxdata = spi_rx_data;
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_dv"}, 32'(spi_tx_dv), 0);
      check({tag, "_txdata"}, 32'(spi_tx_data), 0);
      check({tag, "_s_ready"}, 32'(s_ready), 1);
      check({tag, "_m_valid"}, 32'(m_valid), 0);
      check({tag, "_m_data"}, 32'(m_data), 0);
      check({tag, "_tx_level"}, 32'(tx_level), 0);
      check({tag, "_rx_level"}, 32'(rx_level), 0);
      check({tag, "_ovf"}, 32'(rx_overflow), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic write_byte(input logic [7:0] b);
      int t = 0;
      while (!s_ready && t < 200) begin
         @(negedge P_clk);
         t++;
      end
      if (!s_ready) check("write_timeout", 0, 1);
      s_valid = 1'b1;
      s_data  = b;
      @(negedge P_clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int t = 0;
      while ((busy || mst_busy || !spi_tx_ready || txq.size() != 0) && t < budget) begin
         @(negedge P_clk);
         t++;
      end
      check({tag, "_quiet_timeout"}, 32'(t < budget), 1);
   endtask

   initial begin
      int t;
      int snap;
      repeat (3) @(negedge P_clk);
      check_reset_values("rst0");
      reset = 1'b0;
      @(negedge P_clk);

      // Single byte into an empty FIFO: DV two edges after the accepting edge.
      write_byte(8'hA5);
      @(posedge P_clk); #1;
      check("a5_dv_early", 32'(spi_tx_dv), 0);
      @(posedge P_clk); #1;
      check("a5_dv", 32'(spi_tx_dv), 1);
      check("a5_txdata", 32'(spi_tx_data), 32'hA5);
      @(negedge P_clk);
      t = 0;
      while (!spi_rx_dv && t < 50) begin @(negedge P_clk); t++; end
      check("a5_loop_timeout", 32'(t < 50), 1);
      @(negedge P_clk);
`ifdef SPI_STREAM_RX_FIFO_EN
      check("a5_m_data", 32'(m_data), 32'hA5);
      m_ready = 1'b1;
      @(negedge P_clk);
      m_ready = 1'b0;
`endif
      wait_quiet("a5", 100);

      // Master stalled: fill the TX FIFO and try one more.
      stall = 1'b1;
      repeat (2) @(negedge P_clk);
      for (int i = 0; i < 16; i++) write_byte(8'(i));
      check("full_tx_level", 32'(tx_level), 16);
      check("full_s_ready", 32'(s_ready), 0);
      check("full_busy", 32'(busy), 1);
      s_valid = 1'b1;
      s_data  = 8'h10;
      repeat (3) @(negedge P_clk);
      s_valid = 1'b0;
      check("refused_tx_level", 32'(tx_level), 16);
      stall = 1'b0;
      wait_quiet("drain16", 400);
      write_byte(8'h10);
      wait_quiet("byte17", 100);
      check("gap_measured", 32'(gap_seen > 0), 1);
`ifdef SPI_STREAM_RX_FIFO_EN
      check("ovf_rx_level", 32'(rx_level), 16);
      check("ovf_flag", 32'(rx_overflow), 1);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_readout", 32'(m_data), i);
         @(negedge P_clk);
      end
      m_ready = 1'b0;
      check("ovf_drained", 32'(rx_level), 0);
      check("ovf_sticky", 32'(rx_overflow), 1);
`else
      check("off_rx_level", 32'(rx_level), 0);
      check("off_m_valid", 32'(m_valid), 0);
`endif

      // Reset while the master is mid-byte with four bytes still queued.
      byte_min = 20;
      byte_max = 20;
      for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
      t = 0;
      while (spi_tx_ready && t < 50) begin @(negedge P_clk); t++; end
      check("wd_ready_timeout", 32'(t < 50), 1);
      repeat (2) @(negedge P_clk);
      check("wd_queued", 32'(tx_level), 4);
      #2 reset = 1'b1;
      #1 check_reset_values("rst_async");
      repeat (2) @(negedge P_clk);
      reset = 1'b0;
      snap = dv_count;
      repeat (40) @(negedge P_clk);
      check("post_reset_no_dv", dv_count, snap);
      check("post_reset_busy", 32'(busy), 0);
      check("post_reset_tx_level", 32'(tx_level), 0);

      // Randomized traffic against the reference model.
      byte_min = 1;
      byte_max = 4;
      for (int i = 0; i < 2500; i++) begin
         s_valid = ($urandom_range(99) < 45);
         s_data  = 8'($urandom);
         m_ready = ($urandom_range(99) < 60);
         @(negedge P_clk);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      wait_quiet("rand", 2000);
      repeat (4) @(negedge P_clk);
      check("rand_tx_level", 32'(tx_level), 0);
      check("rand_rx_level", 32'(rx_level), 0);
      check("rand_busy", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
